// File: rtl/cpu_ram_responder_pkg.sv
// cpu_mem_pkg: shared widths, MMIO address map and enums for the CPU RAM responder.
package cpu_mem_pkg;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {CLEAR, RUN} state_t;
    typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_REG} sel_t;
    function automatic int mmio_cyc(input int depth);
        return depth - 1;
    endfunction
    function automatic int mmio_led(input int depth);
        return depth - 2;
    endfunction
    localparam int MMIO_CYC = mmio_cyc(DEPTH);
    localparam int MMIO_LED = mmio_led(DEPTH);
endpackage

// File: rtl/cpu_ram_responder_array.sv
// cpu_ram_array: plain single-port RAM with registered read-first output.
module cpu_ram_array #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int DEPTH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_din;
        r_dout <= r_mem[i_addr];
    end
    assign o_dout = r_dout;
endmodule

// File: rtl/cpu_ram_responder.sv
// cpu_ram_responder: CPU RAM port with clear-after-reset sweep, cycle-counter and LED MMIO.
// Optional write-first read-during-write enabled by `define CPU_RAM_WRITE_FORWARD_EN.
module cpu_ram_responder #(
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::DATA_W,
    parameter int DEPTH = 2 ** ADDR_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] addr_toRAM,
    input  logic [DATA_W-1:0] data_toRAM,
    output logic [DATA_W-1:0] data_fromRAM,
    output logic              ready,
    output logic [DATA_W-1:0] led_out,
    output logic [31:0]       cyc_cnt
);
    import cpu_mem_pkg::*;
    localparam logic [ADDR_W-1:0] L_CYC = ADDR_W'(mmio_cyc(DEPTH));
    localparam logic [ADDR_W-1:0] L_LED = ADDR_W'(mmio_led(DEPTH));
    localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(DEPTH - 3);
    localparam state_t L_RST_ST = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
`ifdef CPU_RAM_WRITE_FORWARD_EN
    localparam logic L_FWD = 1'b1;
`else
    localparam logic L_FWD = 1'b0;
`endif
    state_t            r_state, w_state;
    sel_t              r_sel, w_sel;
    logic [ADDR_W-1:0] r_ptr, w_ram_addr;
    logic [31:0]       r_cyc;
    logic [DATA_W-1:0] r_led, r_rd, w_rd, w_dout, w_ram_din;
    logic              w_run, w_clr, w_wr, w_fwd, w_ram_we;
    logic              w_is_ram, w_is_led, w_is_cyc;
    always_comb begin
        w_run      = r_state == RUN;
        w_clr      = r_state == CLEAR;
        w_wr       = w_run && wrEn && !rst;
        w_fwd      = L_FWD && wrEn;
        w_is_cyc   = addr_toRAM == L_CYC;
        w_is_led   = addr_toRAM == L_LED;
        w_is_ram   = addr_toRAM < L_LED;
        w_ram_we   = !rst && (w_clr || (w_wr && w_is_ram));
        w_ram_addr = w_clr ? r_ptr : addr_toRAM;
        w_ram_din  = w_clr ? '0 : data_toRAM;
        w_state    = (w_clr && r_ptr == L_LAST) ? RUN : r_state;
        // the region flag is registered with the read so the mux lines up with array dout
        w_sel = !w_run ? SEL_ZERO :
                w_is_ram ? (w_fwd ? SEL_REG : SEL_RAM) :
                (w_is_cyc || w_is_led) ? SEL_REG : SEL_ZERO;
        w_rd  = !w_run ? '0 :
                w_is_cyc ? DATA_W'(r_cyc[15:0]) :
                (w_fwd && (w_is_ram || w_is_led)) ? data_toRAM :
                w_is_led ? r_led : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= L_RST_ST;
            r_ptr   <= '0;
            r_cyc   <= '0;
            r_led   <= '0;
            r_rd    <= '0;
            r_sel   <= SEL_ZERO;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_clr ? r_ptr + 1'b1 : r_ptr;
            r_cyc   <= r_cyc + 32'd1;
            r_led   <= (w_wr && w_is_led) ? data_toRAM : r_led;
            r_rd    <= w_rd;
            r_sel   <= w_sel;
        end
    end
    cpu_ram_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .i_we  (w_ram_we),
        .i_addr(w_ram_addr),
        .i_din (w_ram_din),
        .o_dout(w_dout)
    );
    assign data_fromRAM = (r_sel == SEL_RAM) ? w_dout : r_rd;
    assign ready        = r_state == RUN;
    assign led_out      = r_led;
    assign cyc_cnt      = r_cyc;
endmodule

// File: doc/cpu_ram_responder.md
Name: cpu_ram_responder

Overview:
Memory-side responder for the project CPU's RAM port (wrEn / addr_toRAM / data_toRAM / data_fromRAM). It holds a single-port 16-bit word array with a registered (1-cycle) read and decodes the top two word addresses as memory-mapped I/O: a cycle counter and an output latch. After every reset it runs a clear sweep that zeroes the array, and it raises ready only when the sweep is done. The top level holds the CPU in reset while ready=0.

Parameters:
ADDR_W, 13, word-address width; matches the CPU address port.
DATA_W, 16, word width.
DEPTH, 2**ADDR_W, array words; addresses at or above DEPTH-2 are MMIO.
CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = skip the sweep, ready on the first cycle after reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
wrEn  in  1  write strobe from the CPU.
addr_toRAM  in  ADDR_W  word address from the CPU.
data_toRAM  in  DATA_W  write data from the CPU.
data_fromRAM  out  DATA_W  registered read data to the CPU.
ready  out  1  high when the clear sweep is complete and accesses are honoured.
led_out  out  DATA_W  MMIO output latch.
cyc_cnt  out  32  free-running cycle count, for TB/debug.

Behaviour:
- Interface is fixed: one clock clk; rst is synchronous and active-high.
- Reset values: data_fromRAM=0, ready=0, led_out=0, cyc_cnt=0, FSM=CLEAR (or RUN when CLEAR_ON_RESET=0), clear pointer=0.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr. At ptr=DEPTH-3 (last RAM word) the next state is RUN. The sweep takes DEPTH-2 cycles. CPU inputs are ignored and data_fromRAM holds 0.
  - RUN: ready=1 from the first RUN cycle onward; CLEAR is never re-entered except via rst.
- Read: in RUN, data_fromRAM at edge N+1 reflects addr_toRAM sampled at edge N (latency 1). Output is held when the address is unchanged.
- Write: in RUN with wrEn=1, data_toRAM is stored at addr_toRAM at the edge.
- Read-during-write, same address: data_fromRAM returns the old content (see Optional Feature).
- MMIO (RUN only):
  - DEPTH-1: read returns cyc_cnt[15:0]; writes ignored.
  - DEPTH-2: read returns led_out; write loads led_out.
  - MMIO addresses never touch the array.
- cyc_cnt increments every cycle after reset, including during CLEAR, and wraps from 2^32-1 to 0.
- rst asserted mid-sweep or mid-access: the next edge applies reset values and restarts the sweep from 0. An in-flight write at that edge is dropped.
- Out-of-range address (impossible when DEPTH=2**ADDR_W): reads 0, writes dropped.

Optional Feature:
- Macro: CPU_RAM_WRITE_FORWARD_EN.
- Defined: a same-address read-during-write to the RAM region or to led_out returns the new data_toRAM in the following cycle (write-first).
- Undefined: read-first (old data), which matches FPGA block-RAM default inference.
- The cycle-counter address is unaffected either way.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - ADDR_W and DATA_W constants;
  - MMIO address constants MMIO_CYC=DEPTH-1 and MMIO_LED=DEPTH-2;
  - the FSM state enum {CLEAR, RUN}.
- One natural sub-module, cpu_ram_array: the plain single-port synchronous RAM (we, addr, din, dout), kept separate so it infers block RAM.
- The responder owns the FSM, the MMIO decode and the read mux. The mux selects registered MMIO versus array dout using an address-region flag registered alongside the address.

Test Plan:
- Reset then idle, DEPTH=16 -> ready=0 for 14 cycles and 1 on cycle 15; reading addr 0..13 returns 0x0000.
- Preload mem[5]=0xBEEF (X before the sweep) -> after the sweep, a read of addr 5 returns 0x0000; then write 0x1234 to addr 5 and read on the next cycle -> data_fromRAM=0x1234 exactly one cycle after the address is presented.
- Same cycle wrEn=1, addr=7, data=0xAAAA with old mem[7]=0x5555 -> next cycle returns 0x5555 without the macro and 0xAAAA with CPU_RAM_WRITE_FORWARD_EN.
- Write 0x00FF to DEPTH-2 -> led_out=0x00FF next edge and reads back 0x00FF; RAM word DEPTH-2 is untouched.
- Read DEPTH-1 at cycle k -> returns (k)[15:0]; a write to DEPTH-1 is ignored.
- Assert rst for one cycle during the sweep at ptr=6 -> ready drops, ptr restarts at 0, led_out=0, and the full sweep length repeats.
